// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for the multicycle MIPS-subset datapath.
// Every control output is registered and reflects the state held in state_q.
// The one exception is pc_write in BRANCH, which also depends on the live ALU zero flag.
// While reset is low, or during the first FETCH after release, every control is 0.
// FETCH drives nothing that IR_LD does not drive again, so those zero controls are harmless.
module multicycle_ctrl #(
    parameter int MEM_WAIT = 1,
    parameter int EXC_HALT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       ab_load,
    output logic       aluout_load,
    output logic       reg_write,
    output logic       reg_dest,
    output logic       mem_to_reg,
    output logic       write_src,
    output logic       alu_src_a,
    output logic [3:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] shift_control,
    output logic       exc,
    output logic [1:0] exc_code,
    output logic [4:0] state
);

    typedef enum logic [4:0] {
        ST_FETCH  = 5'd0,
        ST_F_WAIT = 5'd1,
        ST_IR_LD  = 5'd2,
        ST_DECODE = 5'd3,
        ST_R_EXEC = 5'd4,
        ST_R_WB   = 5'd5,
        ST_SH_LD  = 5'd6,
        ST_SH_RUN = 5'd7,
        ST_SH_WB  = 5'd8,
        ST_I_EXEC = 5'd9,
        ST_I_WB   = 5'd10,
        ST_M_ADDR = 5'd11,
        ST_M_RD   = 5'd12,
        ST_M_WAIT = 5'd13,
        ST_LW_WB  = 5'd14,
        ST_M_WR   = 5'd15,
        ST_BRANCH = 5'd16,
        ST_JUMP   = 5'd17,
        ST_EXC    = 5'd18,
        ST_HALT   = 5'd19
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [1:0] CAUSE_OVF = 2'b01;
    localparam logic [1:0] CAUSE_ILL = 2'b10;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    // ALU operation selected by an R-type funct field
    function automatic logic [2:0] alu_op_for(input logic [5:0] f);
        case (f)
            FN_ADD:  return 3'b001;
            FN_SUB:  return 3'b010;
            FN_AND:  return 3'b011;
            FN_XOR:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Shifter operation selected by a shift funct field
    function automatic logic [2:0] shift_op_for(input logic [5:0] f);
        case (f)
            FN_SLL:  return 3'b010;
            FN_SRL:  return 3'b011;
            FN_SRA:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       exc_q, exc_d;
    logic [1:0] exc_code_q, exc_code_d;
    logic       enter_exc;
    logic [1:0] cause;
    logic       is_alu_funct, is_shift_funct;

    logic       pc_write_q, pc_write_d;
    logic [1:0] pc_source_q, pc_source_d;
    logic       i_or_d_q, i_or_d_d;
    logic       mem_write_q, mem_write_d;
    logic       ir_write_q, ir_write_d;
    logic       ab_load_q, ab_load_d;
    logic       aluout_load_q, aluout_load_d;
    logic       reg_write_q, reg_write_d;
    logic       reg_dest_q, reg_dest_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic       write_src_q, write_src_d;
    logic       alu_src_a_q, alu_src_a_d;
    logic [3:0] alu_src_b_q, alu_src_b_d;
    logic [2:0] alu_control_q, alu_control_d;
    logic [2:0] shift_control_q, shift_control_d;
    logic       branch_take;

    // Classify the R-type funct field for DECODE dispatch
    always_comb begin
        is_alu_funct   = (funct == FN_ADD) || (funct == FN_SUB) ||
                         (funct == FN_AND) || (funct == FN_XOR);
        is_shift_funct = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
    end

    // Next-state, wait-counter and exception bookkeeping
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enter_exc = 1'b0;
        cause     = 2'b00;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_F_WAIT;
                cnt_d   = WAIT_INIT;
            end
            ST_F_WAIT, ST_M_WAIT: begin
                // Leave once the decrement reaches zero, so the wait lasts
                // MEM_WAIT cycles (one cycle when MEM_WAIT is 0).
                if (cnt_q <= 3'd1) begin
                    state_d = (state_q == ST_F_WAIT) ? ST_IR_LD : ST_LW_WB;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_IR_LD: state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (is_alu_funct) begin
                            state_d = ST_R_EXEC;
                        end else if (is_shift_funct) begin
                            state_d = ST_SH_LD;
                        end else begin
                            state_d   = ST_EXC;
                            enter_exc = 1'b1;
                            cause     = CAUSE_ILL;
                        end
                    end
                    OP_ADDI:        state_d = ST_I_EXEC;
                    OP_LW, OP_SW:   state_d = ST_M_ADDR;
                    OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                    OP_J:           state_d = ST_JUMP;
                    default: begin
                        state_d   = ST_EXC;
                        enter_exc = 1'b1;
                        cause     = CAUSE_ILL;
                    end
                endcase
            end
            ST_R_EXEC: begin
                if (overflow && ((funct == FN_ADD) || (funct == FN_SUB))) begin
                    state_d   = ST_EXC;
                    enter_exc = 1'b1;
                    cause     = CAUSE_OVF;
                end else begin
                    state_d = ST_R_WB;
                end
            end
            ST_SH_LD:  state_d = ST_SH_RUN;
            ST_SH_RUN: state_d = ST_SH_WB;
            ST_I_EXEC: begin
                if (overflow) begin
                    state_d   = ST_EXC;
                    enter_exc = 1'b1;
                    cause     = CAUSE_OVF;
                end else begin
                    state_d = ST_I_WB;
                end
            end
            ST_M_ADDR: state_d = (opcode == OP_LW) ? ST_M_RD : ST_M_WR;
            ST_M_RD: begin
                state_d = ST_M_WAIT;
                cnt_d   = WAIT_INIT;
            end
            ST_R_WB, ST_SH_WB, ST_I_WB, ST_LW_WB, ST_M_WR, ST_BRANCH, ST_JUMP:
                state_d = ST_FETCH;
            ST_EXC:  state_d = (EXC_HALT != 0) ? ST_HALT : ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
        // The first cause is kept; later exceptions only re-assert exc.
        exc_d = exc_q | enter_exc;
        if (enter_exc && !exc_q) begin
            exc_code_d = cause;
        end else begin
            exc_code_d = exc_code_q;
        end
    end

    // Control word for the state being entered, registered alongside it
    always_comb begin
        pc_write_d      = 1'b0;
        pc_source_d     = 2'd0;
        i_or_d_d        = 1'b0;
        mem_write_d     = 1'b0;
        ir_write_d      = 1'b0;
        ab_load_d       = 1'b0;
        aluout_load_d   = 1'b0;
        reg_write_d     = 1'b0;
        reg_dest_d      = 1'b0;
        mem_to_reg_d    = 1'b0;
        write_src_d     = 1'b0;
        alu_src_a_d     = 1'b0;
        alu_src_b_d     = 4'd0;
        alu_control_d   = 3'b000;
        shift_control_d = 3'b000;
        case (state_d)
            ST_FETCH: begin
                alu_src_b_d   = 4'd3;
                alu_control_d = 3'b001;
            end
            ST_IR_LD: begin
                ir_write_d    = 1'b1;
                pc_write_d    = 1'b1;
                alu_src_b_d   = 4'd3;
                alu_control_d = 3'b001;
            end
            ST_DECODE: begin
                ab_load_d     = 1'b1;
                aluout_load_d = 1'b1;
                alu_src_b_d   = 4'd2;
                alu_control_d = 3'b001;
            end
            ST_R_EXEC: begin
                alu_src_a_d   = 1'b1;
                alu_control_d = alu_op_for(funct);
                aluout_load_d = 1'b1;
            end
            ST_R_WB: begin
                reg_write_d = 1'b1;
                reg_dest_d  = 1'b1;
            end
            ST_SH_LD:  shift_control_d = 3'b001;
            ST_SH_RUN: shift_control_d = shift_op_for(funct);
            ST_SH_WB: begin
                reg_write_d = 1'b1;
                reg_dest_d  = 1'b1;
                write_src_d = 1'b1;
            end
            ST_I_EXEC, ST_M_ADDR: begin
                alu_src_a_d   = 1'b1;
                alu_src_b_d   = 4'd1;
                alu_control_d = 3'b001;
                aluout_load_d = 1'b1;
            end
            ST_I_WB:  reg_write_d = 1'b1;
            ST_M_RD, ST_M_WAIT: i_or_d_d = 1'b1;
            ST_LW_WB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            ST_M_WR: begin
                i_or_d_d    = 1'b1;
                mem_write_d = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_d   = 1'b1;
                alu_control_d = 3'b010;
                pc_source_d   = 2'd1;
            end
            ST_JUMP: begin
                pc_source_d = 2'd2;
                pc_write_d  = 1'b1;
            end
            default: begin
                // F_WAIT, EXC and HALT drive no datapath controls.
                pc_write_d = 1'b0;
            end
        endcase
    end

    // State, counter, exception and control-word registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_FETCH;
            cnt_q           <= 3'd0;
            exc_q           <= 1'b0;
            exc_code_q      <= 2'b00;
            pc_write_q      <= 1'b0;
            pc_source_q     <= 2'd0;
            i_or_d_q        <= 1'b0;
            mem_write_q     <= 1'b0;
            ir_write_q      <= 1'b0;
            ab_load_q       <= 1'b0;
            aluout_load_q   <= 1'b0;
            reg_write_q     <= 1'b0;
            reg_dest_q      <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            write_src_q     <= 1'b0;
            alu_src_a_q     <= 1'b0;
            alu_src_b_q     <= 4'd0;
            alu_control_q   <= 3'b000;
            shift_control_q <= 3'b000;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            exc_q           <= exc_d;
            exc_code_q      <= exc_code_d;
            pc_write_q      <= pc_write_d;
            pc_source_q     <= pc_source_d;
            i_or_d_q        <= i_or_d_d;
            mem_write_q     <= mem_write_d;
            ir_write_q      <= ir_write_d;
            ab_load_q       <= ab_load_d;
            aluout_load_q   <= aluout_load_d;
            reg_write_q     <= reg_write_d;
            reg_dest_q      <= reg_dest_d;
            mem_to_reg_q    <= mem_to_reg_d;
            write_src_q     <= write_src_d;
            alu_src_a_q     <= alu_src_a_d;
            alu_src_b_q     <= alu_src_b_d;
            alu_control_q   <= alu_control_d;
            shift_control_q <= shift_control_d;
        end
    end

    // Conditional PC load in BRANCH: beq takes on zero, bne on not-zero
    always_comb begin
        if (state_q == ST_BRANCH) begin
            if (opcode == OP_BEQ) begin
                branch_take = zero;
            end else begin
                branch_take = ~zero;
            end
        end else begin
            branch_take = 1'b0;
        end
    end

    assign pc_write      = pc_write_q | branch_take;
    assign pc_source     = pc_source_q;
    assign i_or_d        = i_or_d_q;
    assign mem_write     = mem_write_q;
    assign ir_write      = ir_write_q;
    assign ab_load       = ab_load_q;
    assign aluout_load   = aluout_load_q;
    assign reg_write     = reg_write_q;
    assign reg_dest      = reg_dest_q;
    assign mem_to_reg    = mem_to_reg_q;
    assign write_src     = write_src_q;
    assign alu_src_a     = alu_src_a_q;
    assign alu_src_b     = alu_src_b_q;
    assign alu_control   = alu_control_q;
    assign shift_control = shift_control_q;
    assign exc           = exc_q;
    assign exc_code      = exc_code_q;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances are driven one at a time.
// Instance A uses MEM_WAIT=1, EXC_HALT=1; instance B uses MEM_WAIT=3, EXC_HALT=0.
// A model expands each instruction into its expected per-cycle control words.
// A negedge process compares those words with the DUT outputs.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       ab_load;
        logic       aluout_load;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       write_src;
        logic       alu_src_a;
        logic [3:0] alu_src_b;
        logic [2:0] alu_control;
        logic [2:0] shift_control;
        logic       exc;
        logic [1:0] exc_code;
        logic [4:0] state;
    } ctl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [5:0] opcode, funct;
    logic       zero, overflow;

    logic       a_pc_write, a_i_or_d, a_mem_write, a_ir_write, a_ab_load, a_aluout_load;
    logic       a_reg_write, a_reg_dest, a_mem_to_reg, a_write_src, a_alu_src_a, a_exc;
    logic [1:0] a_pc_source, a_exc_code;
    logic [3:0] a_alu_src_b;
    logic [2:0] a_alu_control, a_shift_control;
    logic [4:0] a_state;
    logic       b_pc_write, b_i_or_d, b_mem_write, b_ir_write, b_ab_load, b_aluout_load;
    logic       b_reg_write, b_reg_dest, b_mem_to_reg, b_write_src, b_alu_src_a, b_exc;
    logic [1:0] b_pc_source, b_exc_code;
    logic [3:0] b_alu_src_b;
    logic [2:0] b_alu_control, b_shift_control;
    logic [4:0] b_state;

    multicycle_ctrl #(.MEM_WAIT(1), .EXC_HALT(1)) dut_a (
        .clk(clk), .reset(rst_a), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .pc_write(a_pc_write), .pc_source(a_pc_source),
        .i_or_d(a_i_or_d), .mem_write(a_mem_write), .ir_write(a_ir_write),
        .ab_load(a_ab_load), .aluout_load(a_aluout_load), .reg_write(a_reg_write),
        .reg_dest(a_reg_dest), .mem_to_reg(a_mem_to_reg), .write_src(a_write_src),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_control(a_alu_control),
        .shift_control(a_shift_control), .exc(a_exc), .exc_code(a_exc_code), .state(a_state)
    );

    multicycle_ctrl #(.MEM_WAIT(3), .EXC_HALT(0)) dut_b (
        .clk(clk), .reset(rst_b), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .pc_write(b_pc_write), .pc_source(b_pc_source),
        .i_or_d(b_i_or_d), .mem_write(b_mem_write), .ir_write(b_ir_write),
        .ab_load(b_ab_load), .aluout_load(b_aluout_load), .reg_write(b_reg_write),
        .reg_dest(b_reg_dest), .mem_to_reg(b_mem_to_reg), .write_src(b_write_src),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_control(b_alu_control),
        .shift_control(b_shift_control), .exc(b_exc), .exc_code(b_exc_code), .state(b_state)
    );

    ctl_t obs_a, obs_b, obs_s, cmp_e;
    assign obs_a = {a_pc_write, a_pc_source, a_i_or_d, a_mem_write, a_ir_write, a_ab_load,
                    a_aluout_load, a_reg_write, a_reg_dest, a_mem_to_reg, a_write_src,
                    a_alu_src_a, a_alu_src_b, a_alu_control, a_shift_control, a_exc,
                    a_exc_code, a_state};
    assign obs_b = {b_pc_write, b_pc_source, b_i_or_d, b_mem_write, b_ir_write, b_ab_load,
                    b_aluout_load, b_reg_write, b_reg_dest, b_mem_to_reg, b_write_src,
                    b_alu_src_a, b_alu_src_b, b_alu_control, b_shift_control, b_exc,
                    b_exc_code, b_state};

    bit   sel;          // 0: instance A active, 1: instance B active
    assign obs_s = sel ? obs_b : obs_a;

    int   n_total = 0;
    int   n_pass  = 0;
    int   iod_cnt = 0;
    ctl_t exp_q[$];

    // Model state: sticky exception, latched cause, parked, first FETCH after reset
    bit         m_exc;
    logic [1:0] m_code;
    bit         m_halt;
    bit         m_fresh;
    int         m_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Per-cycle comparison of the active instance against the model queue
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            n_total++;
            if (obs_s === cmp_e) n_pass++;
            else $display("FAIL cycle (expected state %0d): got %h expected %h",
                          cmp_e.state, obs_s, cmp_e);
            if (obs_s.i_or_d) iod_cnt++;
        end
    end

    task automatic push(input ctl_t v, input logic [4:0] st);
        ctl_t w;
        w          = v;
        w.state    = st;
        w.exc      = m_exc;
        w.exc_code = m_code;
        exp_q.push_back(w);
        m_len++;
    endtask

    task automatic raise(input logic [1:0] c);
        ctl_t v;
        if (!m_exc) begin
            m_exc  = 1'b1;
            m_code = c;
        end
        v = '0;
        push(v, 5'd18);
        if (!sel) m_halt = 1'b1;
    endtask

    // Expand one instruction into the control words it must produce
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
        ctl_t v;
        int   nw;
        nw    = sel ? 3 : 1;
        m_len = 0;
        v = '0;
        if (!m_fresh) begin v.alu_src_b = 4'd3; v.alu_control = 3'b001; end
        m_fresh = 1'b0;
        push(v, 5'd0);
        for (int i = 0; i < nw; i++) begin v = '0; push(v, 5'd1); end
        v = '0; v.ir_write = 1'b1; v.pc_write = 1'b1; v.alu_src_b = 4'd3; v.alu_control = 3'b001;
        push(v, 5'd2);
        v = '0; v.ab_load = 1'b1; v.aluout_load = 1'b1; v.alu_src_b = 4'd2; v.alu_control = 3'b001;
        push(v, 5'd3);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h26)) begin
            v = '0; v.alu_src_a = 1'b1; v.aluout_load = 1'b1;
            v.alu_control = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 :
                            (fn == 6'h24) ? 3'b011 : 3'b100;
            push(v, 5'd4);
            if (ov && (fn == 6'h20 || fn == 6'h22)) raise(2'b01);
            else begin v = '0; v.reg_write = 1'b1; v.reg_dest = 1'b1; push(v, 5'd5); end
        end else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
            v = '0; v.shift_control = 3'b001; push(v, 5'd6);
            v = '0; v.shift_control = (fn == 6'h00) ? 3'b010 : (fn == 6'h02) ? 3'b011 : 3'b100;
            push(v, 5'd7);
            v = '0; v.reg_write = 1'b1; v.reg_dest = 1'b1; v.write_src = 1'b1; push(v, 5'd8);
        end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
            v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 4'd1; v.alu_control = 3'b001;
            v.aluout_load = 1'b1;
            push(v, (op == 6'h08) ? 5'd9 : 5'd11);
            if (op == 6'h08) begin
                if (ov) raise(2'b01);
                else begin v = '0; v.reg_write = 1'b1; push(v, 5'd10); end
            end else if (op == 6'h23) begin
                v = '0; v.i_or_d = 1'b1; push(v, 5'd12);
                for (int i = 0; i < nw; i++) push(v, 5'd13);
                v = '0; v.reg_write = 1'b1; v.mem_to_reg = 1'b1; push(v, 5'd14);
            end else begin
                v = '0; v.i_or_d = 1'b1; v.mem_write = 1'b1; push(v, 5'd15);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            v = '0; v.alu_src_a = 1'b1; v.alu_control = 3'b010; v.pc_source = 2'd1;
            v.pc_write = (op == 6'h04) ? z : !z;
            push(v, 5'd16);
        end else if (op == 6'h02) begin
            v = '0; v.pc_source = 2'd2; v.pc_write = 1'b1; push(v, 5'd17);
        end else begin
            raise(2'b10);
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 100;
        do begin
            @(posedge clk);
            budget--;
        end while (exp_q.size() > 0 && budget > 0);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    // Called just after a rising edge with the active instance in FETCH
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
        opcode = op; funct = fn; zero = z; overflow = ov;
        build(op, fn, z, ov);
        wait_drain();
    endtask

    task automatic halt_cycles(input int n);
        ctl_t v;
        for (int i = 0; i < n; i++) begin v = '0; push(v, 5'd19); end
        wait_drain();
    endtask

    // Assert reset on the active instance now, hold two cycles, release
    task automatic apply_reset();
        ctl_t v;
        if (sel) rst_b = 1'b0; else rst_a = 1'b0;
        #1;
        check("async reset outputs", 32'(obs_s), 32'd0);
        exp_q.delete();
        m_exc = 1'b0; m_code = 2'b00; m_halt = 1'b0; m_fresh = 1'b1;
        v = '0;
        push(v, 5'd0);
        @(posedge clk); #1;
        push(v, 5'd0);
        @(posedge clk); #1;
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0;
        opcode = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
        m_exc = 1'b0; m_code = 2'b00; m_halt = 1'b0; m_fresh = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("A reset state", 32'(obs_a), 32'd0);
        check("B reset state", 32'(obs_b), 32'd0);
        rst_a = 1'b1;

        // Instance A: MEM_WAIT=1, EXC_HALT=1
        run(6'h00, 6'h20, 1'b0, 1'b0); check("R add length", m_len, 6);
        run(6'h00, 6'h22, 1'b0, 1'b0);
        run(6'h00, 6'h24, 1'b1, 1'b0);
        run(6'h00, 6'h26, 1'b0, 1'b1);   // xor ignores overflow
        run(6'h00, 6'h00, 1'b0, 1'b0); check("sll length", m_len, 7);
        run(6'h00, 6'h02, 1'b0, 1'b0);
        run(6'h00, 6'h03, 1'b0, 1'b0);
        run(6'h08, 6'h11, 1'b0, 1'b0); check("addi length", m_len, 6);
        run(6'h23, 6'h00, 1'b0, 1'b0); check("lw length", m_len, 8);
        run(6'h2B, 6'h00, 1'b0, 1'b0); check("sw length", m_len, 6);
        run(6'h04, 6'h00, 1'b1, 1'b0); check("beq length", m_len, 5);
        run(6'h05, 6'h00, 1'b1, 1'b0);
        run(6'h04, 6'h00, 1'b0, 1'b0);
        run(6'h05, 6'h00, 1'b0, 1'b0);
        run(6'h02, 6'h00, 1'b0, 1'b0); check("jump length", m_len, 5);
        run(6'h00, 6'h22, 1'b0, 1'b1);   // sub overflow -> EXC -> HALT
        check("A exc after ovf", 32'(a_exc), 32'd1);
        check("A exc_code ovf", 32'(a_exc_code), 32'd1);
        check("A parked in HALT", 32'(a_state), 32'd19);
        opcode = 6'h02;                   // a jump must not release HALT
        halt_cycles(4);
        apply_reset();
        run(6'h08, 6'h00, 1'b0, 1'b1);   // addi overflow after reset
        halt_cycles(2);

        // Instance B: MEM_WAIT=3, EXC_HALT=0
        rst_a = 1'b0;
        sel = 1'b1;
        m_exc = 1'b0; m_code = 2'b00; m_halt = 1'b0; m_fresh = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b1;
        iod_cnt = 0;
        run(6'h23, 6'h00, 1'b0, 1'b0);
        check("lw i_or_d cycles", iod_cnt, 4);
        run(6'h2B, 6'h00, 1'b0, 1'b0);
        run(6'h3F, 6'h00, 1'b0, 1'b0);   // illegal opcode -> EXC -> FETCH
        check("B exc illegal", 32'(b_exc), 32'd1);
        check("B exc_code illegal", 32'(b_exc_code), 32'd2);
        check("B back in FETCH", 32'(b_state), 32'd0);
        run(6'h00, 6'h20, 1'b0, 1'b1);   // later overflow keeps first cause
        check("B exc_code kept", 32'(b_exc_code), 32'd2);
        run(6'h02, 6'h00, 1'b0, 1'b0);
        run(6'h00, 6'h05, 1'b0, 1'b0);   // illegal funct
        run(6'h00, 6'h03, 1'b0, 1'b0);

        // Reset in the middle of the lw memory wait
        opcode = 6'h23; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
        build(6'h23, 6'h00, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("B in M_WAIT before reset", 32'(b_state), 32'd13);
        apply_reset();
        run(6'h08, 6'h00, 1'b0, 1'b0);
        check("B exc cleared by reset", 32'(b_exc), 32'd0);
        run(6'h05, 6'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
